// File: rtl/sm_systole_pipe.sv
// sm_systole_pipe: systolic nearest-neighbour distance pipeline.
// A query vector is compared against VECT_NUM stored vectors in parallel. Each
// of VECT_LEN accumulation stages adds one element's distance term to every
// column's partial sum. One query per cycle; result VECT_LEN+1 edges after accept.
//
// Configuration macro: SM_SQ_DIST_EN
//   defined   -> squared-L2 datapath present, dist_mode_i selects L1/L2
//   undefined -> L1 only, dist_mode_i ignored
//
// Ports:
//   clk, rst (async, active-high)
//   ld_en_i / ld_addr_i / ld_vec_i / ld_lbl_i : load one stored column
//   in_valid_i / in_ready_o / in_vec_i / dist_mode_i : query input
//   out_valid_o / out_sum_o / out_lbl_o : per-column result (pulse + held regs)
//   busy_o : any stage holds a query; ld_err_o : sticky rejected-load flag
module sm_systole_pipe #(
  parameter int unsigned SUM_LEN  = 12,
  parameter int unsigned WORD_LEN = 6,
  parameter int unsigned LBL_LEN  = 10,
  parameter int unsigned VECT_NUM = 6,
  parameter int unsigned VECT_LEN = 4,
  parameter int unsigned ADDR_LEN = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_en_i,
  input  logic [ADDR_LEN-1:0]          ld_addr_i,
  input  logic [VECT_LEN*WORD_LEN-1:0] ld_vec_i,
  input  logic [LBL_LEN-1:0]           ld_lbl_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [VECT_LEN*WORD_LEN-1:0] in_vec_i,
  input  logic                         dist_mode_i,
  output logic                         out_valid_o,
  output logic [VECT_NUM*SUM_LEN-1:0]  out_sum_o,
  output logic [VECT_NUM*LBL_LEN-1:0]  out_lbl_o,
  output logic                         busy_o,
  output logic                         ld_err_o
);

  localparam int unsigned VecW  = VECT_LEN * WORD_LEN;
  localparam int unsigned TermW = 2 * WORD_LEN;
  // One spare bit so the saturation test sees the carry out of SUM_LEN.
  localparam int unsigned AccW  = ((SUM_LEN > TermW) ? SUM_LEN : TermW) + 1;
  localparam int unsigned NStg  = VECT_LEN + 1;
  localparam int unsigned AccTotW = VECT_NUM * SUM_LEN;

  // Stored columns
  logic [VecW-1:0]     mem_q [VECT_NUM];
  logic [VecW-1:0]     mem_d [VECT_NUM];
  logic [LBL_LEN-1:0]  lbl_q [VECT_NUM];
  logic [LBL_LEN-1:0]  lbl_d [VECT_NUM];
  logic [VECT_NUM-1:0] loaded_q, loaded_d;
  logic                ld_err_q, ld_err_d;

  // Pipeline: stage s holds the partial sums of elements [0, s).
  logic [NStg-1:0]     vld_q, vld_d;
  logic [VecW-1:0]     qry_q [VECT_LEN];
  logic [VecW-1:0]     qry_d [VECT_LEN];
  logic [AccTotW-1:0]  acc_q [NStg];
  logic [AccTotW-1:0]  acc_d [NStg];
`ifdef SM_SQ_DIST_EN
  logic [VECT_LEN-1:0] mode_q, mode_d;
`else
  logic                unused_dist_mode;
  assign unused_dist_mode = dist_mode_i;
`endif

  logic               out_valid_q, out_valid_d;
  logic [AccTotW-1:0] out_sum_q, out_sum_d;
  logic [VECT_NUM*LBL_LEN-1:0] out_lbl_q, out_lbl_d;

  logic busy, accept, ld_ok, addr_ok;

`ifdef SM_SQ_DIST_EN
  function automatic logic [TermW-1:0] elem_dist(input logic [WORD_LEN-1:0] a,
                                                 input logic [WORD_LEN-1:0] b,
                                                 input logic sq);
    logic [WORD_LEN-1:0] diff;
    logic [TermW-1:0]    diff_w;
    diff   = (a >= b) ? (a - b) : (b - a);
    diff_w = {{WORD_LEN{1'b0}}, diff};
    // diff < 2^WORD_LEN so the square fits in TermW bits exactly.
    return sq ? (diff_w * diff_w) : diff_w;
  endfunction
`else
  function automatic logic [TermW-1:0] elem_dist(input logic [WORD_LEN-1:0] a,
                                                 input logic [WORD_LEN-1:0] b);
    logic [WORD_LEN-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return {{WORD_LEN{1'b0}}, diff};
  endfunction
`endif

  function automatic logic [SUM_LEN-1:0] sat_add(input logic [SUM_LEN-1:0] s,
                                                 input logic [TermW-1:0]   t);
    logic [AccW-1:0] w;
    w = AccW'(s) + AccW'(t);
    return (w > AccW'({SUM_LEN{1'b1}})) ? {SUM_LEN{1'b1}} : w[SUM_LEN-1:0];
  endfunction

  assign busy       = |vld_q;
  assign in_ready_o = ~ld_en_i;
  assign accept     = in_valid_i & ~ld_en_i;
  assign addr_ok    = ({1'b0, ld_addr_i} < (ADDR_LEN+1)'(VECT_NUM));
  assign ld_ok      = ld_en_i & ~busy & addr_ok;

  // Load path
  always_comb begin
    mem_d    = mem_q;
    lbl_d    = lbl_q;
    loaded_d = loaded_q;
    ld_err_d = ld_err_q | (ld_en_i & ~ld_ok);
    for (int c = 0; c < VECT_NUM; c++) begin
      if (ld_ok && (ld_addr_i == ADDR_LEN'(c))) begin
        mem_d[c]    = ld_vec_i;
        lbl_d[c]    = ld_lbl_i;
        loaded_d[c] = 1'b1;
      end
    end
  end

  // Pipeline advance
  always_comb begin
    vld_d    = {vld_q[NStg-2:0], accept};
    qry_d[0] = in_vec_i;
    acc_d[0] = '0;
`ifdef SM_SQ_DIST_EN
    mode_d   = {mode_q[VECT_LEN-2:0], dist_mode_i};
`endif
    for (int s = 1; s < VECT_LEN; s++) begin
      qry_d[s] = qry_q[s-1];
    end
    for (int s = 1; s < NStg; s++) begin
      acc_d[s] = '0;
      for (int c = 0; c < VECT_NUM; c++) begin
        acc_d[s][c*SUM_LEN +: SUM_LEN] = sat_add(
          acc_q[s-1][c*SUM_LEN +: SUM_LEN],
          elem_dist(qry_q[s-1][(s-1)*WORD_LEN +: WORD_LEN],
                    mem_q[c][(s-1)*WORD_LEN +: WORD_LEN]
`ifdef SM_SQ_DIST_EN
                    , mode_q[s-1]
`endif
                    ));
      end
    end
  end

  // Result register: unloaded columns report all-ones / zero label.
  always_comb begin
    out_valid_d = vld_q[NStg-1];
    out_sum_d   = out_sum_q;
    out_lbl_d   = out_lbl_q;
    if (vld_q[NStg-1]) begin
      for (int c = 0; c < VECT_NUM; c++) begin
        out_sum_d[c*SUM_LEN +: SUM_LEN] = loaded_q[c] ? acc_q[NStg-1][c*SUM_LEN +: SUM_LEN]
                                                      : {SUM_LEN{1'b1}};
        out_lbl_d[c*LBL_LEN +: LBL_LEN] = loaded_q[c] ? lbl_q[c] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < VECT_NUM; c++) begin
        mem_q[c] <= '0;
        lbl_q[c] <= '0;
      end
      for (int s = 0; s < VECT_LEN; s++) qry_q[s] <= '0;
      for (int s = 0; s < NStg; s++)     acc_q[s] <= '0;
      loaded_q    <= '0;
      ld_err_q    <= 1'b0;
      vld_q       <= '0;
`ifdef SM_SQ_DIST_EN
      mode_q      <= '0;
`endif
      out_valid_q <= 1'b0;
      out_sum_q   <= '1;
      out_lbl_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      lbl_q       <= lbl_d;
      qry_q       <= qry_d;
      acc_q       <= acc_d;
      loaded_q    <= loaded_d;
      ld_err_q    <= ld_err_d;
      vld_q       <= vld_d;
`ifdef SM_SQ_DIST_EN
      mode_q      <= mode_d;
`endif
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_lbl_q   <= out_lbl_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_lbl_o   = out_lbl_q;
  assign busy_o      = busy;
  assign ld_err_o    = ld_err_q;

endmodule

// File: tb/tb_sm_systole_pipe.sv
// Randomised + directed bench for sm_systole_pipe against a transaction-level model.
module tb_sm_systole_pipe;
  localparam int SL = 12, WL = 6, LL = 10, VN = 6, VL = 4, AL = 3;
  localparam int SatMax = (1 << SL) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en, in_valid, dist_mode;
  logic [AL-1:0]     ld_addr;
  logic [VL*WL-1:0]  ld_vec, in_vec;
  logic [LL-1:0]     ld_lbl;
  logic              in_ready, out_valid, busy, ld_err;
  logic [VN*SL-1:0]  out_sum;
  logic [VN*LL-1:0]  out_lbl;

  always #5 clk = ~clk;

  sm_systole_pipe #(
    .SUM_LEN(SL), .WORD_LEN(WL), .LBL_LEN(LL), .VECT_NUM(VN), .VECT_LEN(VL), .ADDR_LEN(AL)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_vec_i(ld_vec), .ld_lbl_i(ld_lbl),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_vec_i(in_vec), .dist_mode_i(dist_mode),
    .out_valid_o(out_valid), .out_sum_o(out_sum), .out_lbl_o(out_lbl),
    .busy_o(busy), .ld_err_o(ld_err)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stored columns, pending results with their due cycle.
  typedef struct {
    int               due;
    logic [VN*SL-1:0] s;
    logic [VN*LL-1:0] l;
  } res_t;

  int               mem [VN][VL];
  int               mlbl [VN];
  bit               mloaded [VN];
  bit               merr;
  res_t             pend [$];
  logic [VN*SL-1:0] exp_sum;
  logic [VN*LL-1:0] exp_lbl;
  int               cyc = 0;

  function automatic res_t predict(input logic [VL*WL-1:0] q, input bit mode);
    res_t r;
    r.due = 0;
    r.s   = '0;
    r.l   = '0;
    for (int c = 0; c < VN; c++) begin
      int total = 0;
      if (!mloaded[c]) begin
        r.s[c*SL +: SL] = '1;
      end else begin
        for (int k = 0; k < VL; k++) begin
          int a = int'(q[k*WL +: WL]);
          int d = (a > mem[c][k]) ? a - mem[c][k] : mem[c][k] - a;
`ifdef SM_SQ_DIST_EN
          total += mode ? d * d : d;
`else
          total += d;
`endif
        end
        if (total > SatMax) total = SatMax;
        r.s[c*SL +: SL] = SL'(total);
        r.l[c*LL +: LL] = LL'(mlbl[c]);
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < VN; c++) begin
      for (int k = 0; k < VL; k++) mem[c][k] = 0;
      mlbl[c]    = 0;
      mloaded[c] = 1'b0;
    end
    merr = 1'b0;
    pend.delete();
    exp_sum = '1;
    exp_lbl = '0;
  endtask

  // One clock: predict the edge from current inputs, then compare every output.
  task automatic tick();
    bit   acc, ok, exp_ov;
    res_t r;
    #1;
    check("in_ready", in_ready, !ld_en);
    acc = in_valid && !ld_en;
    ok  = ld_en && (pend.size() == 0) && (int'(ld_addr) < VN);
    if (acc) r = predict(in_vec, dist_mode);
    @(posedge clk);
    #1;
    cyc++;
    if (ok) begin
      for (int k = 0; k < VL; k++) mem[ld_addr][k] = int'(ld_vec[k*WL +: WL]);
      mlbl[ld_addr]    = int'(ld_lbl);
      mloaded[ld_addr] = 1'b1;
    end else if (ld_en) begin
      merr = 1'b1;
    end
    if (acc) begin
      r.due = cyc + VL + 1;
      pend.push_back(r);
    end
    exp_ov = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_ov  = 1'b1;
      exp_sum = pend[0].s;
      exp_lbl = pend[0].l;
      void'(pend.pop_front());
    end
    check("out_valid", out_valid, exp_ov);
    check("out_sum", out_sum, exp_sum);
    check("out_lbl", out_lbl, exp_lbl);
    check("busy", busy, pend.size() != 0);
    check("ld_err", ld_err, merr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, {VN*SL{1'b1}});
    check("rst_lbl", out_lbl, 0);
    check("rst_ld_err", ld_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [VL*WL-1:0] pack(input int e0, input int e1, input int e2,
                                            input int e3);
    return {WL'(e3), WL'(e2), WL'(e1), WL'(e0)};
  endfunction

  task automatic load(input int addr, input logic [VL*WL-1:0] v, input int lbl);
    ld_en = 1'b1; ld_addr = AL'(addr); ld_vec = v; ld_lbl = LL'(lbl);
    tick();
    ld_en = 1'b0;
  endtask

  // Accept one query, flip dist_mode while in flight, wait (bounded) for the result.
  task automatic run_query(input string tag, input logic [VL*WL-1:0] v, input bit m,
                           input int exp0);
    int n = 0;
    bit got = 1'b0;
    in_vec = v; dist_mode = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; dist_mode = !m;
    while (n < 10 && !got) begin
      tick();
      n++;
      got = out_valid;
    end
    check({tag, "_latency"}, n, VL + 1);
    check({tag, "_col0"}, out_sum[SL-1:0], exp0);
  endtask

  initial begin
    int pulses;
    ld_en = 0; in_valid = 0; dist_mode = 0; ld_addr = 0;
    ld_vec = 0; ld_lbl = 0; in_vec = 0;
    do_reset();

    // Basic L1 / L2 on column 0, unloaded columns saturate.
    load(0, pack(1, 2, 3, 4), 5);
    run_query("l1", pack(4, 2, 0, 4), 1'b0, 6);
    check("l1_lbl0", out_lbl[LL-1:0], 5);
    check("l1_col1", out_sum[SL +: SL], SatMax);
    check("l1_lbl1", out_lbl[LL +: LL], 0);
`ifdef SM_SQ_DIST_EN
    run_query("l2", pack(4, 2, 0, 4), 1'b1, 18);
`else
    run_query("l2", pack(4, 2, 0, 4), 1'b1, 6);
`endif

    // Saturation boundary.
    load(0, pack(0, 0, 0, 0), 9);
`ifdef SM_SQ_DIST_EN
    run_query("sat_l2", pack(63, 63, 63, 63), 1'b1, SatMax);
`else
    run_query("sat_l2", pack(63, 63, 63, 63), 1'b1, 252);
`endif
    run_query("sat_l1", pack(63, 63, 63, 63), 1'b0, 252);

    // Back-to-back queries with alternating modes.
    load(1, pack(10, 20, 30, 40), 77);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      in_vec = pack(i * 7, 50, 3, 33); dist_mode = (i == 1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("b2b_pulses", pulses, 3);

    // Rejected loads: while busy, and out-of-range address while idle.
    do_reset();
    load(0, pack(1, 2, 3, 4), 5);
    check("ld_err_clean", ld_err, 0);
    in_vec = pack(4, 2, 0, 4); dist_mode = 0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    load(0, pack(9, 9, 9, 9), 1);
    check("ld_err_busy", ld_err, 1);
    for (int i = 0; i < 6; i++) tick();
    load(7, pack(9, 9, 9, 9), 1);
    check("ld_err_addr", ld_err, 1);
    run_query("after_rej", pack(4, 2, 0, 4), 1'b0, 6);
    check("after_rej_lbl", out_lbl[LL-1:0], 5);

    // Reset with a query in flight.
    do_reset();
    load(2, pack(5, 5, 5, 5), 3);
    in_vec = pack(1, 1, 1, 1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", out_sum, {VN*SL{1'b1}});
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ld_en     = ($urandom_range(0, 7) == 0);
      ld_addr   = AL'($urandom_range(0, 7));
      ld_vec    = VL*WL'($urandom);
      ld_lbl    = LL'($urandom);
      in_valid  = ($urandom_range(0, 2) == 0);
      in_vec    = VL*WL'($urandom);
      dist_mode = 1'($urandom);
      tick();
    end
    ld_en = 0; in_valid = 0;
    for (int i = 0; i < 8; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm_systole_pipe.md
SM_SYSTOLE_PIPE -- requirements
Module: sm_systole_pipe

Interface
REQ-001 Parameters (name, default, meaning): SUM_LEN, 12, distance width; WORD_LEN, 6, element width (unsigned); LBL_LEN, 10, label width; VECT_NUM, 6, stored vectors (columns); VECT_LEN, 4, elements per vector; ADDR_LEN, 3, load address width, 2^ADDR_LEN >= VECT_NUM.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ld_en  input  1  load strobe for one stored vector and its label.
REQ-005 ld_addr  input  ADDR_LEN  column index to load.
REQ-006 ld_vec  input  VECT_LEN*WORD_LEN  vector to store; element k at bits [k*WORD_LEN +: WORD_LEN].
REQ-007 ld_lbl  input  LBL_LEN  label to store.
REQ-008 in_valid  input  1  query vector present.
REQ-009 in_ready  output  1  query accepted when in_valid && in_ready.
REQ-010 in_vec  input  VECT_LEN*WORD_LEN  query vector, same packing as ld_vec.
REQ-011 dist_mode  input  1  0 = L1 (sum of abs differences), 1 = squared L2.
REQ-012 out_valid  output  1  one-cycle pulse, result registers updated.
REQ-013 out_sum  output  VECT_NUM*SUM_LEN  per-column distance; column c at [c*SUM_LEN +: SUM_LEN].
REQ-014 out_lbl  output  VECT_NUM*LBL_LEN  per-column stored label, same packing.
REQ-015 busy  output  1  any pipeline stage holds a valid query.
REQ-016 ld_err  output  1  sticky flag: rejected load.

Function
REQ-017 Pipeline SHALL have VECT_LEN accumulation stages; stage k adds dist(query[k], stored[c][k]) to column c's partial sum, all columns in parallel.
REQ-018 Throughput SHALL be one query per cycle; in_ready = !ld_en.
REQ-019 out_valid SHALL assert exactly VECT_LEN+1 posedges after the accepting posedge; out_sum/out_lbl update on that same edge and hold until the next result.
REQ-020 dist_mode SHALL be sampled at acceptance and carried with the query; mode changes never affect in-flight queries.
REQ-021 Per-element term: L1 = |a-b|; L2 = (a-b)^2, 2*WORD_LEN bits; accumulation SHALL saturate at 2^SUM_LEN-1, never wrap.
REQ-022 Columns never loaded since reset SHALL report out_sum = all-ones and out_lbl = 0.
REQ-023 Load SHALL be accepted only when ld_en && !busy && ld_addr < VECT_NUM; stored vector, label and loaded-flag update on that edge.
REQ-024 ld_en with busy=1 or ld_addr >= VECT_NUM SHALL be ignored (no state change) and set ld_err.
REQ-025 Reloading an already loaded column SHALL overwrite it; later queries use the new data.
REQ-026 ld_en and in_valid in the same cycle: load takes priority, query not accepted (in_ready=0).

Reset
REQ-027 On rst: all stage valid bits, loaded-flags, ld_err, out_valid cleared; out_sum all-ones, out_lbl 0; stored vectors/labels 0; in-flight queries discarded, no out_valid afterwards.
REQ-028 After rst deasserts, in_ready=1 on the first cycle (absent ld_en).

Configuration
REQ-029 Macro SM_SQ_DIST_EN: defined -> squared-L2 datapath present, dist_mode honoured; undefined -> no multipliers, dist_mode ignored, all queries computed as L1.

Verification
REQ-030 Defaults; load col 0 = (1,2,3,4), lbl 5; query (4,2,0,4), mode 0 -> out_valid 5 cycles after accept, col0 sum 6, lbl 5, cols 1-5 sum 4095.
REQ-031 Same, mode 1 with SM_SQ_DIST_EN -> col0 sum 18; without macro -> 6.
REQ-032 Col 0 = (0,0,0,0), query (63,63,63,63), mode 1 -> sum 4095 (saturated); mode 0 -> 252.
REQ-033 Queries on 3 consecutive cycles with modes 0,1,0 -> 3 consecutive out_valid pulses, each with its own mode's result.
REQ-034 ld_en while busy, and ld_addr=7 while idle -> stored data unchanged, ld_err=1 until rst.
REQ-035 rst asserted 2 cycles after accept -> no out_valid, outputs at reset values, busy=0.
